mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter that shares the single AXI4-Lite-style memory slave between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read and write). It sits between the core's IFU/LSU bus ports and the memory model. It grants exactly one transaction at a time, routes all channels of the winner to the slave, and holds the loser stalled with ready low.

## Interface
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of R/W channels; strobe width is DATA_W/8
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- m0_araddr/m0_arvalid/m0_arready  in/in/out  ADDR_W/1/1  IFU read address channel
- m0_rdata/m0_rresp/m0_rvalid/m0_rready  out/out/out/in  DATA_W/1/1/1  IFU read data channel
- m1_araddr/m1_arvalid/m1_arready  in/in/out  ADDR_W/1/1  LSU read address channel
- m1_rdata/m1_rresp/m1_rvalid/m1_rready  out/out/out/in  DATA_W/1/1/1  LSU read data channel
- m1_awaddr/m1_awvalid/m1_awready  in/in/out  ADDR_W/1/1  LSU write address channel
- m1_wdata/m1_wstrb/m1_wvalid/m1_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  LSU write data channel
- m1_bresp/m1_bvalid/m1_bready  out/out/in  1/1/1  LSU write response channel
- s_araddr/s_arvalid/s_arready, s_rdata/s_rresp/s_rvalid/s_rready, s_awaddr/s_awvalid/s_awready, s_wdata/s_wstrb/s_wvalid/s_wready, s_bresp/s_bvalid/s_bready: slave-side mirror of the above, directions inverted

## Operation
- States: IDLE, M0_AR, M0_R, M1_AR, M1_R, M1_W, M1_B; 3-bit state register.
- IDLE arbitration, fixed priority: m1 write (m1_awvalid or m1_wvalid) > m1_arvalid > m0_arvalid. Winner state: M1_W, M1_AR, M0_AR. No request: stay IDLE.
- While in IDLE, all master readies are 0 and all slave valids are 0.
- M0_AR/M1_AR: connect granted araddr/arvalid to the slave and s_arready back to the master. On s_arvalid&&s_arready, go to M0_R/M1_R.
- M0_R/M1_R: connect s_rdata, s_rresp and s_rvalid to the granted master, and its rready to s_rready. On s_rvalid&&s_rready, go to IDLE.
- M1_W: aw_done and w_done flags are cleared on entry. Drive s_awvalid = m1_awvalid&&!aw_done and s_wvalid = m1_wvalid&&!w_done, with the matching readies routed back. A flag sets on its own handshake. Go to M1_B once both are done; this includes both handshakes in the same cycle, or the second one completing later.
- M1_B: connect s_bresp/s_bvalid to m1 and m1_bready to the slave. On the b handshake, go to IDLE.
- Non-granted master: arready/awready/wready/rvalid/bvalid = 0. rdata/rresp/bresp are don't-care but driven from the slave mux, never X.
- Slave address, data and strobe outputs are passed through from the granted master. They are 0 in IDLE.
- Master valid dropping while its address phase is granted: no handshake occurs, and the state holds until the handshake happens.
- No outstanding-transaction overlap: the next grant is only decided after returning to IDLE.

## Timing
- Reset: state=IDLE, flags=0. Every valid/ready output to masters and slave is 0. Reset mid-transaction aborts it immediately, with no completion signalled.
- Grant latency: 1 cycle. A request seen in IDLE at edge N is presented to the slave in cycle N+1.
- The ready/valid paths within a granted state are combinational pass-through, adding zero extra cycles.
- Minimum read occupancy: IDLE + AR + R = 3 cycles with an always-ready slave and master.
- Back-to-back requests: at least one IDLE cycle between transactions.
- Starvation: m0 can starve under continuous m1 traffic. This is accepted, because the LSU only issues when the IFU stalls.

## Test plan
- Single m0 read: m0_araddr=0x8000_0000; slave returns rdata=0x0000_0413 after 5 cycles -> m0_rvalid for exactly one cycle with 0x0000_0413, m1_rvalid stays 0.
- Simultaneous m0 and m1 reads at the same edge (0x8000_0000 / 0x8000_0100) -> m1 is served first, m0_arready stays 0 until m1's r handshake, then m0 completes.
- m1 write 0x8000_0010, data 0xDEAD_BEEF, wstrb=4'b0011, aw and w in the same cycle -> one slave aw+w handshake, then m1_bvalid=1 with bresp=0; a following read returns 0x0000_BEEF.
- Split write: awvalid at cycle 2, wvalid at cycle 5 -> s_awvalid drops after its handshake, M1_B is entered only after the w handshake, and no duplicate aw is issued.
- Master back-pressure: m0_rready held 0 for 4 cycles after s_rvalid -> s_rready=0 during that time, the state stays M0_R, and the data is stable.
- Reset asserted in M1_B -> the next cycle is IDLE, all valids and readies are 0, and a new m0 read then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4-Lite-style memory slave between the instruction
// fetch unit (master 0, read-only) and the load/store unit (master 1, read and
// write). One transaction is granted at a time from IDLE with fixed priority
// m1 write > m1 read > m0 read. All channels of the winner are passed through
// combinationally. The loser sees ready low until the arbiter returns to IDLE.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0: instruction fetch, read only
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    // master 1: load/store, read and write
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic                  m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    // shared memory slave
    output logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic                  s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic                  s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M0_AR = 3'd1,
        M0_R  = 3'd2,
        M1_AR = 3'd3,
        M1_R  = 3'd4,
        M1_W  = 3'd5,
        M1_B  = 3'd6
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   aw_done_r;
    logic   w_done_r;
    logic   aw_done_next_s;
    logic   w_done_next_s;
    logic   aw_fire_s;
    logic   w_fire_s;

    // Response payloads come straight from the slave; only valid is gated,
    // so a non-granted master sees a defined value that it must ignore.
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_bresp = s_bresp;

    // Grant state and write-phase completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            aw_done_r <= aw_done_next_s;
            w_done_r  <= w_done_next_s;
        end
    end

    // Arbitration, next-state and channel routing for the granted master.
    always_comb begin
        state_next_s   = state_r;
        aw_done_next_s = aw_done_r;
        w_done_next_s  = w_done_r;
        aw_fire_s      = 1'b0;
        w_fire_s       = 1'b0;
        m0_arready     = 1'b0;
        m0_rvalid      = 1'b0;
        m1_arready     = 1'b0;
        m1_rvalid      = 1'b0;
        m1_awready     = 1'b0;
        m1_wready      = 1'b0;
        m1_bvalid      = 1'b0;
        s_araddr       = {ADDR_W{1'b0}};
        s_arvalid      = 1'b0;
        s_rready       = 1'b0;
        s_awaddr       = {ADDR_W{1'b0}};
        s_awvalid      = 1'b0;
        s_wdata        = {DATA_W{1'b0}};
        s_wstrb        = {(DATA_W/8){1'b0}};
        s_wvalid       = 1'b0;
        s_bready       = 1'b0;

        case (state_r)
            IDLE: begin
                // Flags are cleared here so every write phase starts fresh.
                aw_done_next_s = 1'b0;
                w_done_next_s  = 1'b0;
                if (m1_awvalid || m1_wvalid) begin
                    state_next_s = M1_W;
                end else if (m1_arvalid) begin
                    state_next_s = M1_AR;
                end else if (m0_arvalid) begin
                    state_next_s = M0_AR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            M0_AR: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid;
                m0_arready = s_arready;
                if (m0_arvalid && s_arready) begin
                    state_next_s = M0_R;
                end else begin
                    state_next_s = M0_AR;
                end
            end
            M0_R: begin
                m0_rvalid = s_rvalid;
                s_rready  = m0_rready;
                if (s_rvalid && m0_rready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = M0_R;
                end
            end
            M1_AR: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid;
                m1_arready = s_arready;
                if (m1_arvalid && s_arready) begin
                    state_next_s = M1_R;
                end else begin
                    state_next_s = M1_AR;
                end
            end
            M1_R: begin
                m1_rvalid = s_rvalid;
                s_rready  = m1_rready;
                if (s_rvalid && m1_rready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = M1_R;
                end
            end
            M1_W: begin
                // Each half is offered to the slave only until it has been
                // accepted, so a split write never duplicates a handshake.
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid && !aw_done_r;
                m1_awready = s_awready && !aw_done_r;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid && !w_done_r;
                m1_wready  = s_wready && !w_done_r;
                aw_fire_s  = m1_awvalid && s_awready && !aw_done_r;
                w_fire_s   = m1_wvalid && s_wready && !w_done_r;
                aw_done_next_s = aw_done_r || aw_fire_s;
                w_done_next_s  = w_done_r || w_fire_s;
                if (aw_done_next_s && w_done_next_s) begin
                    state_next_s = M1_B;
                end else begin
                    state_next_s = M1_W;
                end
            end
            M1_B: begin
                m1_bvalid = s_bvalid;
                s_bready  = m1_bready;
                if (s_bvalid && m1_bready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = M1_B;
                end
            end
            default: begin
                state_next_s   = IDLE;
                aw_done_next_s = 1'b0;
                w_done_next_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory slave, a vector
// table of transactions, directed corner sequences and a randomized phase with
// two concurrent master streams checked against a word-array memory model.
module tb_mem_arbiter;

    localparam int TMO = 200;

    logic        clk;
    logic        rst;
    logic [31:0] m0_araddr;
    logic        m0_arvalid, m0_arready;
    logic [31:0] m0_rdata;
    logic        m0_rresp, m0_rvalid, m0_rready;
    logic [31:0] m1_araddr;
    logic        m1_arvalid, m1_arready;
    logic [31:0] m1_rdata;
    logic        m1_rresp, m1_rvalid, m1_rready;
    logic [31:0] m1_awaddr;
    logic        m1_awvalid, m1_awready;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_wvalid, m1_wready;
    logic        m1_bresp, m1_bvalid, m1_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic        s_rresp, s_rvalid, s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic        s_bresp, s_bvalid, s_bready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m0_rv_cnt, m1_rv_cnt, aw_hs_cnt, w_hs_cnt;

    // slave model state
    logic [31:0] mem [0:255];
    bit          mem_ready = 1'b0;
    bit          slv_rand;
    int          r_delay;
    logic        rd_busy, aw_got, w_got;
    int          rd_cnt;
    logic [31:0] rd_addr, aw_addr, w_data_l;
    logic [3:0]  w_strb_l;

    // reference memory
    logic [31:0] ref_mem [0:255];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 0)      return 32'h0000_0413;
        else if (i == 4) return 32'h0000_0000;
        else             return {16'h1234, b, ~b};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural AXI4-Lite memory slave, one outstanding read and one write
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end
        if (rst) begin
            s_arready <= 1'b0; s_rvalid <= 1'b0; s_rdata <= 32'h0; s_rresp <= 1'b0;
            s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0; s_bresp <= 1'b0;
            rd_busy <= 1'b0; rd_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            rd_addr <= 32'h0; aw_addr <= 32'h0; w_data_l <= 32'h0; w_strb_l <= 4'h0;
        end else begin
            if (s_arvalid && s_arready) begin
                s_arready <= 1'b0;
                rd_busy   <= 1'b1;
                rd_addr   <= s_araddr;
                if (!slv_rand && r_delay == 0) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= mem[s_araddr[9:2]];
                end else begin
                    rd_cnt <= slv_rand ? int'($urandom_range(0, 2)) : r_delay - 1;
                end
            end else if (rd_busy && !s_rvalid) begin
                if (rd_cnt == 0) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= mem[rd_addr[9:2]];
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end else if (!rd_busy) begin
                s_arready <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
                rd_busy  <= 1'b0;
            end
            if (s_awvalid && s_awready) begin
                s_awready <= 1'b0; aw_got <= 1'b1; aw_addr <= s_awaddr;
            end else if (!aw_got) begin
                s_awready <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (s_wvalid && s_wready) begin
                s_wready <= 1'b0; w_got <= 1'b1; w_data_l <= s_wdata; w_strb_l <= s_wstrb;
            end else if (!w_got) begin
                s_wready <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end else if (aw_got && w_got && !s_bvalid) begin
                s_bvalid <= 1'b1;
                s_bresp  <= 1'b0;
                mem[aw_addr[9:2]] <= merge(mem[aw_addr[9:2]], w_data_l, w_strb_l);
            end
        end
    end

    // per-cycle protocol invariants and event counters
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("excl_arready", m0_arready && m1_arready, 1'b0);
                chk("excl_rvalid", m0_rvalid && m1_rvalid, 1'b0);
                chk("rvalid_no_src", (m0_rvalid || m1_rvalid) && !s_rvalid, 1'b0);
                chk("bvalid_no_src", m1_bvalid && !s_bvalid, 1'b0);
                chk("dup_aw", s_awvalid && aw_got, 1'b0);
                chk("dup_w", s_wvalid && w_got, 1'b0);
                chk("early_bready", s_bready && !(aw_got && w_got), 1'b0);
                if (m0_rvalid) m0_rv_cnt++;
                if (m1_rvalid) m1_rv_cnt++;
                if (s_awvalid && s_awready) aw_hs_cnt++;
                if (s_wvalid && s_wready) w_hs_cnt++;
            end
        end
    end

    task automatic do_read(input int m, input logic [31:0] addr, input int rdly,
                           output logic [31:0] data, output int ar_cyc, output int r_cyc);
        int n; int hold; logic got; logic v; logic [31:0] rd; logic [31:0] first;
        data = 32'h0; first = 32'h0;
        if (m == 0) begin m0_araddr = addr; m0_arvalid = 1'b1; end
        else        begin m1_araddr = addr; m1_arvalid = 1'b1; end
        n = 0; got = 1'b0;
        while (!got) begin
            @(negedge clk);
            got = (m == 0) ? m0_arready : m1_arready;
            @(posedge clk); #1;
            if (++n > TMO) begin chk("ar_timeout", 1'b1, 1'b0); break; end
        end
        ar_cyc = cyc;
        if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
        if (m == 0) m0_rready = (rdly == 0); else m1_rready = (rdly == 0);
        n = 0; hold = 0; got = 1'b0;
        while (!got) begin
            @(negedge clk);
            v  = (m == 0) ? m0_rvalid : m1_rvalid;
            rd = (m == 0) ? m0_rdata : m1_rdata;
            if (v && ((m == 0) ? m0_rready : m1_rready)) begin
                data = rd; got = 1'b1;
            end else if (v) begin
                chk("bp_s_rready", s_rready, 1'b0);
                if (hold == 0) first = rd;
                else chk("bp_data_stable", rd, first);
                hold++;
            end
            @(posedge clk); #1;
            if (!got && hold >= rdly) begin
                if (m == 0) m0_rready = 1'b1; else m1_rready = 1'b1;
            end
            if (++n > TMO) begin chk("r_timeout", 1'b1, 1'b0); break; end
        end
        r_cyc = cyc;
        if (m == 0) m0_rready = 1'b0; else m1_rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input bit hold_b, output logic resp);
        int n; logic got;
        resp = 1'b1;
        m1_bready = !hold_b;
        fork
            begin
                int k; logic g;
                repeat (aw_dly) begin @(posedge clk); #1; end
                m1_awaddr = addr; m1_awvalid = 1'b1; k = 0; g = 1'b0;
                while (!g) begin
                    @(negedge clk); g = m1_awready;
                    @(posedge clk); #1;
                    if (++k > TMO) begin chk("aw_timeout", 1'b1, 1'b0); break; end
                end
                m1_awvalid = 1'b0;
            end
            begin
                int k; logic g;
                repeat (w_dly) begin @(posedge clk); #1; end
                m1_wdata = d; m1_wstrb = s; m1_wvalid = 1'b1; k = 0; g = 1'b0;
                while (!g) begin
                    @(negedge clk); g = m1_wready;
                    @(posedge clk); #1;
                    if (++k > TMO) begin chk("w_timeout", 1'b1, 1'b0); break; end
                end
                m1_wvalid = 1'b0;
            end
        join
        n = 0; got = 1'b0;
        while (!got) begin
            @(negedge clk);
            if (m1_bvalid) begin got = 1'b1; resp = m1_bresp; end
            @(posedge clk); #1;
            if (++n > TMO) begin chk("b_timeout", 1'b1, 1'b0); break; end
        end
        if (!hold_b) m1_bready = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_vr"}, {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                            m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 12'h000);
        chk({name, "_payload"}, {s_araddr, s_awaddr} | {32'h0, s_wdata} | {60'h0, s_wstrb}, 64'h0);
    endtask

    typedef struct {
        int          kind;   // 0: m0 read, 1: m1 read, 2: m1 write
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          lat;
        logic [31:0] exp;    // read data, or bresp for writes
    } vec_t;

    initial begin
        vec_t        vt [9];
        logic [31:0] d, d1, wd;
        logic [3:0]  ws;
        logic        resp;
        int          a, r, a1, r1, c0;

        rst = 1'b1; slv_rand = 1'b0; r_delay = 1;
        m0_araddr = 32'h0; m0_arvalid = 1'b0; m0_rready = 1'b0;
        m1_araddr = 32'h0; m1_arvalid = 1'b0; m1_rready = 1'b0;
        m1_awaddr = 32'h0; m1_awvalid = 1'b0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        m1_wvalid = 1'b0; m1_bready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        vt[0] = '{0, 32'h8000_0000, 32'h0,         4'h0, 5, 32'h0000_0413};
        vt[1] = '{1, 32'h8000_0100, 32'h0,         4'h0, 1, 32'h1234_40BF};
        vt[2] = '{2, 32'h8000_0010, 32'hDEAD_BEEF, 4'h3, 1, 32'h0};
        vt[3] = '{0, 32'h8000_0010, 32'h0,         4'h0, 2, 32'h0000_BEEF};
        vt[4] = '{2, 32'h8000_0020, 32'hCAFE_F00D, 4'hC, 1, 32'h0};
        vt[5] = '{1, 32'h8000_0020, 32'h0,         4'h0, 3, 32'hCAFE_08F7};
        vt[6] = '{2, 32'h8000_03FC, 32'h0102_0304, 4'hF, 1, 32'h0};
        vt[7] = '{0, 32'h8000_03FC, 32'h0,         4'h0, 0, 32'h0102_0304};
        vt[8] = '{0, 32'h8000_0004, 32'h0,         4'h0, 1, 32'h1234_01FE};

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_quiet("idle_after_reset");

        // table-driven transactions
        for (int i = 0; i < 9; i++) begin
            r_delay = vt[i].lat;
            m0_rv_cnt = 0; m1_rv_cnt = 0; aw_hs_cnt = 0; w_hs_cnt = 0;
            if (vt[i].kind == 2) begin
                do_write(vt[i].addr, vt[i].wdata, vt[i].strb, 0, 0, 1'b0, resp);
                chk($sformatf("vec%0d_bresp", i), resp, vt[i].exp);
                chk($sformatf("vec%0d_aw_count", i), aw_hs_cnt, 1);
                chk($sformatf("vec%0d_w_count", i), w_hs_cnt, 1);
                ref_mem[vt[i].addr[9:2]] = merge(ref_mem[vt[i].addr[9:2]], vt[i].wdata, vt[i].strb);
            end else begin
                do_read(vt[i].kind, vt[i].addr, 0, d, a, r);
                chk($sformatf("vec%0d_rdata", i), d, vt[i].exp);
                chk($sformatf("vec%0d_own_rvalid_cycles", i), (vt[i].kind == 0) ? m0_rv_cnt : m1_rv_cnt, 1);
                chk($sformatf("vec%0d_other_rvalid_cycles", i), (vt[i].kind == 0) ? m1_rv_cnt : m0_rv_cnt, 0);
            end
            @(posedge clk); #1;
        end

        // minimum occupancy: IDLE + AR + R with an always-ready slave
        r_delay = 0;
        for (int k = 0; k < 2; k++) begin
            c0 = cyc;
            do_read(0, 32'h8000_0008, 0, d, a, r);
            chk("min_occupancy_cycles", r - c0, 3);
            chk("min_occupancy_rdata", d, ref_mem[2]);
        end

        // simultaneous m0 and m1 reads: m1 wins, m0 granted only afterwards
        r_delay = 1;
        fork
            do_read(0, 32'h8000_0000, 0, d, a, r);
            do_read(1, 32'h8000_0100, 0, d1, a1, r1);
        join
        chk("simul_m1_rdata", d1, ref_mem[8'h40]);
        chk("simul_m0_rdata", d, ref_mem[0]);
        chk("simul_m0_after_m1", a > r1, 1'b1);

        // split write: aw first, w three cycles later
        @(posedge clk); #1;
        aw_hs_cnt = 0; w_hs_cnt = 0;
        do_write(32'h8000_0258, 32'h7654_3210, 4'hF, 0, 3, 1'b0, resp);
        chk("split_bresp", resp, 1'b0);
        chk("split_aw_count", aw_hs_cnt, 1);
        chk("split_w_count", w_hs_cnt, 1);
        ref_mem[150] = merge(ref_mem[150], 32'h7654_3210, 4'hF);
        do_read(1, 32'h8000_0258, 0, d, a, r);
        chk("split_readback", d, 32'h7654_3210);

        // master back-pressure: rready low for four cycles after rvalid
        r_delay = 2;
        do_read(0, 32'h8000_000C, 4, d, a, r);
        chk("bp_rdata", d, ref_mem[3]);

        // reset while waiting in the write response phase
        do_write(32'h8000_0320, 32'h5555_AAAA, 4'hF, 0, 0, 1'b1, resp);
        chk("pre_reset_bvalid", m1_bvalid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_quiet("reset_in_b");
        rst = 1'b0;
        ref_mem[200] = 32'h5555_AAAA;
        @(posedge clk); #1;
        check_quiet("idle_after_abort");
        do_read(0, 32'h8000_0000, 0, d, a, r);
        chk("post_reset_read", d, 32'h0000_0413);

        // randomized concurrent traffic: m0 reads low half, m1 owns high half
        slv_rand = 1'b1;
        fork
            begin
                int idx;
                for (int k = 0; k < 40; k++) begin
                    idx = $urandom_range(0, 127);
                    do_read(0, 32'h8000_0000 | (32'(idx) << 2), $urandom_range(0, 2), d, a, r);
                    chk("rnd_m0_rdata", d, ref_mem[idx]);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                int idx;
                logic [31:0] dd; logic rp; int aa, rr;
                for (int k = 0; k < 40; k++) begin
                    idx = $urandom_range(128, 255);
                    if ($urandom_range(0, 1) == 1) begin
                        wd = $urandom; ws = 4'($urandom_range(1, 15));
                        do_write(32'h8000_0000 | (32'(idx) << 2), wd, ws,
                                 $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, rp);
                        chk("rnd_bresp", rp, 1'b0);
                        ref_mem[idx] = merge(ref_mem[idx], wd, ws);
                    end else begin
                        do_read(1, 32'h8000_0000 | (32'(idx) << 2), $urandom_range(0, 2), dd, aa, rr);
                        chk("rnd_m1_rdata", dd, ref_mem[idx]);
                    end
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global time limit
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "time limit reached");
    end

endmodule
